// File: rtl/spi_dcs_pkg.sv
// Shared types and constants for the two-chip-select SPI master.
package spi_dcs_pkg;

  typedef enum logic [2:0] {
    IDLE,
    A_SHIFT,
    A_HOLD,
    GAP,
    D_SHIFT,
    D_HOLD,
    DONE
  } dcs_state_t;

  // Mode-0 idle levels
  localparam logic SCL_IDLE = 1'b0;
  localparam logic SDI_IDLE = 1'b0;
  localparam logic CS_IDLE  = 1'b1;

  function automatic int unsigned dcs_latency(input int unsigned wa,
                                              input int unsigned wd,
                                              input int unsigned h);
    return 2 * h * (wa + wd) + 3 * h + 1;
  endfunction

  function automatic int max_width(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_dcs_shift_engine.sv
// MSB-first mode-0 shifter: half-period timer, bit counter and a shared TX/RX
// register. Data is loaded left-aligned; received bits collect at the LSB end.
module spi_dcs_shift_engine
  import spi_dcs_pkg::*;
#(
  parameter int W   = 16,
  parameter int H   = 4,
  parameter int NBW = $clog2(W + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           clear,
  input  logic [NBW-1:0] nbits,
  input  logic [W-1:0]   din,
  input  logic           sdo,
  output logic           scl,
  output logic           sdi,
  output logic           phase_end,
  output logic [W-1:0]   dout
);

  localparam int HW = $clog2(H + 1);
  localparam logic [HW-1:0] H_LOAD = HW'(H - 1);

  logic           busy;
  logic [HW-1:0]  hcnt;
  logic [NBW-1:0] bcnt;
  logic [W-1:0]   shreg;
  logic           sdo_bit;

  assign dout      = shreg;
  assign phase_end = busy && (hcnt == '0) && scl && (bcnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      hcnt    <= '0;
      bcnt    <= '0;
      shreg   <= '0;
      sdo_bit <= 1'b0;
      scl     <= SCL_IDLE;
      sdi     <= SDI_IDLE;
    end else if (clear) begin
      busy <= 1'b0;
      hcnt <= '0;
      bcnt <= '0;
      scl  <= SCL_IDLE;
      sdi  <= SDI_IDLE;
    end else if (load) begin
      busy  <= 1'b1;
      shreg <= din;
      sdi   <= din[W-1];
      scl   <= SCL_IDLE;
      hcnt  <= H_LOAD;
      bcnt  <= nbits - NBW'(1);
    end else if (busy) begin
      if (hcnt != '0) begin
        hcnt <= hcnt - HW'(1);
      end else begin
        hcnt <= H_LOAD;
        if (!scl) begin
          scl     <= 1'b1;
          sdo_bit <= sdo;
        end else begin
          // falling edge: commit the sampled bit and present the next one
          scl   <= 1'b0;
          shreg <= {shreg[W-2:0], sdo_bit};
          if (bcnt == '0) begin
            busy <= 1'b0;
          end else begin
            bcnt <= bcnt - NBW'(1);
            sdi  <= shreg[W-2];
          end
        end
      end
    end
  end

endmodule

// File: rtl/spi_dcs_master.sv
// SPI mode-0 master for the address-CS / data-CS slave protocol.
// Sequences chip selects, hold and gap timing around one shift engine.
module spi_dcs_master
  import spi_dcs_pkg::*;
#(
  parameter int width_addr = 8,
  parameter int width_data = 16,
  parameter int sck_half   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [width_addr-1:0] addr,
  input  logic [width_data-1:0] wdata,
  output logic                  ready,
  output logic                  done,
  output logic [width_data-1:0] rdata,
  output logic                  spi_scl,
  output logic                  spi_sdi,
  input  logic                  spi_sdo,
  output logic                  spi_cs_addr,
  output logic                  spi_cs_data
);

  localparam int W   = max_width(width_addr, width_data);
  localparam int NBW = $clog2(W + 1);
  localparam int TW  = $clog2(sck_half + 1);
  localparam logic [TW-1:0] T_LOAD = TW'(sck_half - 1);

  dcs_state_t            state;
  logic [TW-1:0]         tmr;
  logic [width_data-1:0] wdata_q;

  logic           accept, gap_end;
  logic           eng_load, eng_clear, eng_phase_end;
  logic [NBW-1:0] eng_nbits;
  logic [W-1:0]   eng_din, eng_dout, addr_al, wdata_al;

  assign addr_al  = W'(addr) << (W - width_addr);
  assign wdata_al = W'(wdata_q) << (W - width_data);

  always_comb begin
    accept    = (state == IDLE) && start;
    gap_end   = (state == GAP) && (tmr == '0);
    eng_load  = accept || gap_end;
    eng_nbits = accept ? NBW'(width_addr) : NBW'(width_data);
    eng_din   = accept ? addr_al : wdata_al;
    eng_clear = ((state == A_HOLD) || (state == D_HOLD)) && (tmr == '0);
  end

  spi_dcs_shift_engine #(
    .W   (W),
    .H   (sck_half),
    .NBW (NBW)
  ) u_engine (
    .clk       (clk),
    .rst       (rst),
    .load      (eng_load),
    .clear     (eng_clear),
    .nbits     (eng_nbits),
    .din       (eng_din),
    .sdo       (spi_sdo),
    .scl       (spi_scl),
    .sdi       (spi_sdi),
    .phase_end (eng_phase_end),
    .dout      (eng_dout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tmr         <= '0;
      wdata_q     <= '0;
      ready       <= 1'b1;
      done        <= 1'b0;
      rdata       <= '0;
      spi_cs_addr <= CS_IDLE;
      spi_cs_data <= CS_IDLE;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            wdata_q     <= wdata;
            ready       <= 1'b0;
            spi_cs_addr <= 1'b0;
            state       <= A_SHIFT;
          end
        end
        A_SHIFT: begin
          if (eng_phase_end) begin
            tmr   <= T_LOAD;
            state <= A_HOLD;
          end
        end
        A_HOLD: begin
          if (tmr == '0) begin
            spi_cs_addr <= CS_IDLE;
            tmr         <= T_LOAD;
            state       <= GAP;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        GAP: begin
          if (tmr == '0) begin
            spi_cs_data <= 1'b0;
            state       <= D_SHIFT;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        D_SHIFT: begin
          if (eng_phase_end) begin
            tmr   <= T_LOAD;
            state <= D_HOLD;
          end
        end
        D_HOLD: begin
          if (tmr == '0) begin
            spi_cs_data <= CS_IDLE;
            done        <= 1'b1;
            rdata       <= eng_dout[width_data-1:0];
            state       <= DONE;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_dcs_master.sv
// Bench for spi_dcs_master: slave/loopback reference against bus-level expectations.
module tb_spi_dcs_master;

  localparam int WA = 8, WD = 16, H = 4;
  localparam int WA1 = 4, WD1 = 32, H1 = 6;
  localparam int N0 = 2 * H * (WA + WD) + 3 * H + 1;
  localparam int N1 = 2 * H1 * (WA1 + WD1) + 3 * H1 + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          start = 1'b0;
  logic [WA-1:0] addr  = '0;
  logic [WD-1:0] wdata = '0;
  logic          ready, done, spi_scl, spi_sdi, spi_sdo, spi_cs_addr, spi_cs_data;
  logic [WD-1:0] rdata;

  logic           start1 = 1'b0;
  logic [WA1-1:0] addr1  = '0;
  logic [WD1-1:0] wdata1 = '0;
  logic           ready1, done1, scl1, sdi1, sdo1, cs_addr1, cs_data1;
  logic [WD1-1:0] rdata1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spi_dcs_master #(.width_addr(WA), .width_data(WD), .sck_half(H)) u_dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .wdata(wdata),
    .ready(ready), .done(done), .rdata(rdata), .spi_scl(spi_scl),
    .spi_sdi(spi_sdi), .spi_sdo(spi_sdo), .spi_cs_addr(spi_cs_addr),
    .spi_cs_data(spi_cs_data)
  );

  spi_dcs_master #(.width_addr(WA1), .width_data(WD1), .sck_half(H1)) u_dut_w (
    .clk(clk), .rst(rst), .start(start1), .addr(addr1), .wdata(wdata1),
    .ready(ready1), .done(done1), .rdata(rdata1), .spi_scl(scl1),
    .spi_sdi(sdi1), .spi_sdo(sdo1), .spi_cs_addr(cs_addr1),
    .spi_cs_data(cs_data1)
  );

  // Slave reference: captures bits on SCL rise, drives its response MSB first,
  // first bit on CS fall and the next one after each SCL fall.
  logic          loop_mode = 1'b0;
  logic [2:0]    dly = '0;
  logic [WD-1:0] sl_resp = '0;
  int            sl_idx = 0;
  logic [WA-1:0] sl_addr = '0;
  logic [WD-1:0] sl_data = '0;
  int rises_a = 0, rises_d = 0, lo_a = 0, lo_d = 0, viol = 0, done_cnt = 0;
  logic p_scl = 1'b0, p_csa = 1'b1, p_csd = 1'b1;

  always @(posedge clk) dly <= {dly[1:0], spi_sdi};

  assign spi_sdo = loop_mode ? dly[2] :
                   ((sl_idx < WD) ? sl_resp[WD-1-sl_idx] : 1'b0);

  always @(negedge clk) begin
    if (!spi_cs_addr && p_csa) begin
      rises_a = 0; rises_d = 0; lo_a = 0; lo_d = 0;
    end
    if (!spi_cs_addr && !spi_cs_data) viol++;
    if (spi_cs_addr && spi_cs_data && spi_sdi) viol++;
    if (!spi_cs_addr) lo_a++;
    if (!spi_cs_data) lo_d++;
    if (done) done_cnt++;
    if (!spi_cs_data && p_csd) sl_idx = 0;
    if (spi_scl && !p_scl) begin
      if (!spi_cs_addr) begin sl_addr = {sl_addr[WA-2:0], spi_sdi}; rises_a++; end
      if (!spi_cs_data) begin sl_data = {sl_data[WD-2:0], spi_sdi}; rises_d++; end
    end
    if (!spi_scl && p_scl && !spi_cs_data) sl_idx++;
    p_scl = spi_scl; p_csa = spi_cs_addr; p_csd = spi_cs_data;
  end

  // Wide instance runs in loopback only
  logic [2:0]     dly1 = '0;
  logic [WA1-1:0] cap_a1 = '0;
  logic [WD1-1:0] cap_d1 = '0;
  int r_a1 = 0, r_d1 = 0, viol1 = 0;
  logic p_scl1 = 1'b0, p_csa1 = 1'b1;

  always @(posedge clk) dly1 <= {dly1[1:0], sdi1};
  assign sdo1 = dly1[2];

  always @(negedge clk) begin
    if (!cs_addr1 && p_csa1) begin r_a1 = 0; r_d1 = 0; end
    if (!cs_addr1 && !cs_data1) viol1++;
    if (scl1 && !p_scl1) begin
      if (!cs_addr1) begin cap_a1 = {cap_a1[WA1-2:0], sdi1}; r_a1++; end
      if (!cs_data1) begin cap_d1 = {cap_d1[WD1-2:0], sdi1}; r_d1++; end
    end
    p_scl1 = scl1; p_csa1 = cs_addr1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called in a cycle where ready is expected high; start is accepted this cycle.
  task automatic run_txn(input logic [WA-1:0] a, input logic [WD-1:0] w,
                         input logic [WD-1:0] resp, input logic [WD-1:0] exp_rd,
                         input bit keep, input int spur_a, input int spur_b,
                         input int rst_at, input string tag);
    int  done_cyc = 0;
    bit  aborted  = 0;
    check($sformatf("%s_ready", tag), ready, 1'b1);
    addr = a; wdata = w; sl_resp = resp; start = 1'b1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      tick();
      if (!keep) start = (cyc == spur_a) || (cyc == spur_b);
      if (cyc == spur_a || cyc == spur_b) begin
        addr = WA'($urandom); wdata = WD'($urandom);
      end
      if (rst_at > 0 && cyc == rst_at) rst = 1'b1;
      if (rst_at > 0 && cyc == rst_at + 1) begin
        check($sformatf("%s_rst_csd", tag), spi_cs_data, 1'b1);
        check($sformatf("%s_rst_csa", tag), spi_cs_addr, 1'b1);
        check($sformatf("%s_rst_scl", tag), spi_scl, 1'b0);
        check($sformatf("%s_rst_sdi", tag), spi_sdi, 1'b0);
        check($sformatf("%s_rst_ready", tag), ready, 1'b1);
        check($sformatf("%s_rst_done", tag), done, 1'b0);
        rst = 1'b0;
        aborted = 1;
        break;
      end
      if (done) begin done_cyc = cyc; break; end
    end
    if (!aborted) begin
      check($sformatf("%s_done_cycle", tag), done_cyc, N0);
      check($sformatf("%s_rdata", tag), rdata, exp_rd);
      check($sformatf("%s_slave_addr", tag), sl_addr, a);
      check($sformatf("%s_slave_data", tag), sl_data, w);
      check($sformatf("%s_rises_a", tag), rises_a, WA);
      check($sformatf("%s_rises_d", tag), rises_d, WD);
      check($sformatf("%s_csa_low", tag), lo_a, 2 * H * WA + H);
      check($sformatf("%s_csd_low", tag), lo_d, 2 * H * WD + H);
    end
  endtask

  initial begin
    int d0;
    logic [WD-1:0] r;

    repeat (3) tick();
    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_rdata", rdata, '0);
    check("rst_scl", spi_scl, 1'b0);
    check("rst_sdi", spi_sdi, 1'b0);
    check("rst_csa", spi_cs_addr, 1'b1);
    check("rst_csd", spi_cs_data, 1'b1);
    rst = 1'b0;
    repeat (2) tick();

    run_txn(8'hA5, 16'h3C96, 16'h5AF0, 16'h5AF0, 0, 0, 0, 0, "basic");

    // loopback, back-to-back with start held high
    repeat (3) tick();
    loop_mode = 1'b1;
    run_txn(WA'($urandom), 16'hFFFF, 16'h0000, 16'hFFFF, 1, 0, 0, 0, "b2b_1");
    tick();
    run_txn(WA'($urandom), 16'h0001, 16'h0000, 16'h0001, 0, 0, 0, 0, "b2b_2");
    tick();
    check("b2b_idle_ready", ready, 1'b1);
    loop_mode = 1'b0;

    for (int i = 0; i < 50; i++) begin
      repeat ($urandom_range(1, 3)) tick();
      r = WD'($urandom);
      run_txn(WA'($urandom), WD'($urandom), r, r, 0, 0, 0, 0, $sformatf("rnd%0d", i));
    end

    // spurious starts mid-transaction
    tick();
    d0 = done_cnt;
    r  = WD'($urandom);
    run_txn(WA'($urandom), WD'($urandom), r, r, 0, 10, 150, 0, "spur");
    repeat (300) tick();
    check("spur_one_done", done_cnt - d0, 1);
    check("spur_rdata_held", rdata, r);
    check("spur_ready", ready, 1'b1);

    // reset inside the data phase
    d0 = done_cnt;
    run_txn(WA'($urandom), WD'($urandom), WD'($urandom), '0, 0, 0, 0, 80, "abort");
    repeat (250) tick();
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_rdata", rdata, '0);
    r = WD'($urandom);
    run_txn(WA'($urandom), WD'($urandom), r, r, 0, 0, 0, 0, "after_abort");
    check("no_cs_overlap", viol, 0);

    // wide parameter set, loopback
    begin
      int done_cyc = 0;
      tick();
      check("w_ready", ready1, 1'b1);
      addr1 = WA1'($urandom); wdata1 = WD1'($urandom); start1 = 1'b1;
      for (int cyc = 1; cyc <= 600; cyc++) begin
        tick();
        start1 = 1'b0;
        if (done1) begin done_cyc = cyc; break; end
      end
      check("w_done_cycle", done_cyc, N1);
      check("w_rdata", rdata1, wdata1);
      check("w_addr_bits", cap_a1, addr1);
      check("w_data_bits", cap_d1, wdata1);
      check("w_rises_a", r_a1, WA1);
      check("w_rises_d", r_d1, WD1);
      check("w_no_overlap", viol1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_dcs_master.md
Name: spi_dcs_master

Overview:
SPI mode-0 master that drives the two-chip-select (address CS, data CS) slave protocol from the FPGA side; used by the test harness and for FPGA-to-FPGA links.
- One transaction has two phases: an address phase under spi_cs_addr, then a full-duplex data phase under spi_cs_data.
- Both phases shift MSB first.
- The parallel request interface is start/ready/done.

Parameters:
width_addr, 8, address phase bit count (>=2)
width_data, 16, data phase bit count (>=2)
sck_half, 4, clk cycles per SCL half-period; also CS setup, hold and gap length (>=4, so the slave's 2-flop synchronisers keep up)

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  synchronous, active-high reset
start  in  1  transaction request, honoured only when ready=1
addr  in  width_addr  address, captured on accepted start
wdata  in  width_data  write data, captured on accepted start
ready  out  1  high in IDLE
done  out  1  one-cycle pulse when the transaction completes
rdata  out  width_data  data shifted in during the data phase
spi_scl  out  1  SPI clock, idles low
spi_sdi  out  1  master-out serial data
spi_sdo  in  1  master-in serial data
spi_cs_addr  out  1  address chip select, active low
spi_cs_data  out  1  data chip select, active low

Behaviour:
- Interface fixed: one clock; reset is synchronous and active-high.
- Reset values: spi_scl=0, spi_sdi=0, spi_cs_addr=1, spi_cs_data=1, ready=1, done=0, rdata=0, state IDLE.
- Reset mid-transaction aborts the transfer; the idle levels above appear on the next clk edge.
- All SPI outputs are registered. H = sck_half.
- States: IDLE -> A_SHIFT -> A_HOLD -> GAP -> D_SHIFT -> D_HOLD -> DONE -> IDLE.
- IDLE: start=1 captures addr/wdata into shift registers and deasserts ready.
  - Next cycle: spi_cs_addr=0 and spi_sdi=addr MSB.
  - start while ready=0 is ignored and not queued.
- *_SHIFT, per bit:
  - SCL low for H cycles, then high for H cycles.
  - spi_sdi changes only on the cycle SCL falls, or on the CS-fall cycle for the first bit.
  - In D_SHIFT, spi_sdo is sampled into the receive shift register on the cycle SCL is driven high.
  - A bit counter covers width bits; after the last high half, SCL returns low.
- *_HOLD: CS stays low and SCL low for H cycles, then CS rises.
- GAP: both CS high for H cycles.
  - Then spi_cs_data=0 and spi_sdi=wdata MSB.
  - The first SCL rise comes H cycles after the CS fall; the slave loads its first sdo bit on CS fall.
- DONE: one cycle with done=1.
  - rdata is updated in the same cycle and holds until the next done.
  - ready=1 the following cycle.
- spi_cs_addr and spi_cs_data are never low simultaneously.
- spi_sdi=0 whenever both CS are high.
- Latency: the done cycle is N = 2H(width_addr+width_data)+3H+1 cycles after the accepted start cycle. Defaults give N=205.
  - spi_cs_addr low for cycles 1..68.
  - spi_cs_data low for cycles 73..204.
- Back-to-back: start asserted in the first ready cycle is accepted, so the minimum period is N+1.

Decomposition:
- Package spi_dcs_pkg holds:
  - the state enum (IDLE, A_SHIFT, A_HOLD, GAP, D_SHIFT, D_HOLD, DONE);
  - the SPI mode-0 idle-level constants;
  - a function returning N for given widths and sck_half.
- Sub-module spi_dcs_shift_engine:
  - contains the half-period counter, bit counter and MSB-first TX/RX shift register (width = max of both widths);
  - control inputs: load, nbits; outputs: scl, sdi, phase_end.
  - The top FSM instantiates it once and sequences CS and phases around it.

Test Plan:
1. After reset with defaults, start, addr=0xA5, wdata=0x3C96, slave model returns 0x5AF0 -> spi_cs_addr pulse carries 10100101 on rising SCL; data phase carries 0x3C96; rdata=0x5AF0 with done in cycle 205.
2. Loopback (spi_sdo tied to spi_sdi with 3-cycle delay), wdata=0xFFFF then 0x0001 back-to-back (start held high) -> rdata 0xFFFF then 0x0001; second start is accepted in the first ready cycle.
3. Instantiate the existing slave as DUT partner, sck_half=4, 50 random addr/Din/wdata -> slave Addr and Dout match sent values, master rdata matches slave Din on every transaction; monitor checks no CS overlap.
4. start pulsed during cycles 10 and 150 of an active transaction -> ignored; exactly one done; rdata unchanged by the spurious starts.
5. rst=1 at cycle 80 (inside GAP/D_SHIFT) -> next edge: spi_cs_data=1, spi_scl=0, spi_sdi=0, ready=1, done never pulses; the next transaction completes correctly.
6. Parameter sweep width_addr=4, width_data=32, sck_half=6 -> exactly 4 and 32 SCL rises per CS; done at 2*6*36+18+1=451.
